// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU datapath stages.
package fpu_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    PackNorm,
    PackZero,
    PackInf
  } pack_sel_e;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic unf;
  } flags_t;

endpackage

// File: rtl/fpu_pack.sv
// Combinational IEEE 754 packer: normal word, signed zero or signed infinity.
module fpu_pack
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   sign,
  input  logic [EXP_W-1:0]       exp,
  input  logic [MAN_W-1:0]       frac,
  input  pack_sel_e              sel,
  output logic [EXP_W+MAN_W:0]   word
);

  always_comb begin
    word = {sign, exp, frac};
    case (sel)
      PackZero: word = {sign, {(EXP_W + MAN_W){1'b0}}};
      PackInf:  word = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      default:  word = {sign, exp, frac};
    endcase
  end

endmodule

// File: rtl/fpu_normalize.sv
// Normalise/pack stage after the FPU adder: one-bit-per-cycle renormalisation,
// zero/overflow/underflow detection and IEEE 754 single-precision packing.
module fpu_normalize
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W        = 8,
  parameter int unsigned MAN_W        = 23,
  parameter int unsigned FLUSH_DENORM = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [MAN_W+1:0]   in_mant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_result,
  output logic               out_zero,
  output logic               out_ovf,
  output logic               out_unf
);

  localparam int unsigned   CntW    = $clog2(MAN_W + 2);
  localparam logic [CntW-1:0] CntMax = CntW'(MAN_W + 1);
  localparam logic [EXP_W:0] ExpMax = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] ExpOne = {{EXP_W{1'b0}}, 1'b1};

  // Only flush-to-zero is implemented; the parameter is kept for interface stability.
  logic unused_flush;
  assign unused_flush = (FLUSH_DENORM == 1);

  state_e            state_q, state_d;
  logic              live_q;
  logic              sign_q, special_q;
  logic [EXP_W:0]    exp_q, exp_d, exp_inc;
  logic [MAN_W+1:0]  mant_q, mant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;
  flags_t            flags_q, flags_d, flags_new;
  logic              accept, load;

  pack_sel_e         pk_sel;
  logic [EXP_W-1:0]  pk_exp;
  logic [MAN_W-1:0]  pk_frac;
  logic [EXP_W+MAN_W:0] pk_word;

  // in_ready stays low through reset and rises on the first clock after release.
  assign in_ready  = live_q && (state_q == IDLE);
  assign accept    = in_ready && in_valid;
  assign out_valid = (state_q == DONE);
  assign exp_inc   = exp_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    flags_new = '0;
    pk_sel    = PackNorm;
    pk_exp    = exp_q[EXP_W-1:0];
    pk_frac   = mant_q[MAN_W-1:0];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          exp_d   = {1'b0, in_exp};
          mant_d  = in_mant;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        state_d = DONE;
        load    = 1'b1;
        if (special_q) begin
          pk_sel = PackInf;
        end else if (~|mant_q) begin
          pk_sel         = PackZero;
          flags_new.zero = 1'b1;
        end else if (mant_q[MAN_W+1]) begin
          // Carry: shift right, LSB truncated.
          if (exp_inc >= ExpMax) begin
            pk_sel        = PackInf;
            flags_new.ovf = 1'b1;
          end else begin
            pk_exp  = exp_inc[EXP_W-1:0];
            pk_frac = mant_q[MAN_W:1];
          end
        end else if (mant_q[MAN_W]) begin
          pk_sel = PackNorm;
        end else if ((exp_q <= ExpOne) || (cnt_q >= CntMax)) begin
          pk_sel        = PackZero;
          flags_new.unf = 1'b1;
        end else begin
          state_d = SHIFT;
          load    = 1'b0;
          mant_d  = mant_q << 1;
          exp_d   = exp_q - 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    result_d = load ? pk_word : result_q;
    flags_d  = load ? flags_new : flags_q;
  end

  fpu_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_pack (
    .sign (sign_q),
    .exp  (pk_exp),
    .frac (pk_frac),
    .sel  (pk_sel),
    .word (pk_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      live_q    <= 1'b0;
      sign_q    <= 1'b0;
      special_q <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      if (accept) begin
        sign_q    <= in_sign;
        special_q <= (in_exp == {EXP_W{1'b1}});
      end
    end
  end

  assign out_result = result_q;
  assign out_zero   = flags_q.zero;
  assign out_ovf    = flags_q.ovf;
  assign out_unf    = flags_q.unf;

endmodule

// File: tb/tb_fpu_normalize.sv
// Directed bench for fpu_normalize with hand-computed IEEE 754 results.
module tb_fpu_normalize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_mant = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_zero, out_ovf, out_unf;
  logic [31:0] out_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpu_normalize dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Issue one sum, wait for out_valid, check result/flags/latency, optionally retire it.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [24:0] m, input logic [31:0] exp_res,
                        input logic [2:0] exp_flags, input int exp_lat, input bit take);
    int lat;
    bit busy_ok;
    @(negedge clk);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 60) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".result"}, out_result, exp_res);
    chk({tag, ".flags"}, {29'b0, out_zero, out_ovf, out_unf}, {29'b0, exp_flags});
    chk({tag, ".busy"}, {31'b0, busy_ok}, 32'd1);
    if (take) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".drop"}, {31'b0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.result", out_result, 32'h0);
    chk("rst.flags", {29'b0, out_zero, out_ovf, out_unf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel.in_ready", {31'b0, in_ready}, 32'd1);

    run_op("carry",   1'b0, 8'd127, 25'h1000000, 32'h40000000, 3'b000, 2, 1'b1);
    run_op("normal",  1'b0, 8'd127, 25'h0C00000, 32'h3FC00000, 3'b000, 2, 1'b1);
    run_op("cancel",  1'b1, 8'd130, 25'h0000001, 32'hB5800000, 3'b000, 25, 1'b1);
    run_op("zero",    1'b0, 8'd100, 25'h0000000, 32'h00000000, 3'b100, 2, 1'b1);
    run_op("ovf",     1'b0, 8'd254, 25'h1000000, 32'h7F800000, 3'b010, 2, 1'b1);
    run_op("unf",     1'b0, 8'd3,   25'h0000100, 32'h00000000, 3'b001, 4, 1'b1);
    run_op("special", 1'b1, 8'd255, 25'h0800000, 32'hFF800000, 3'b000, 2, 1'b1);
    run_op("frac",    1'b1, 8'd200, 25'h0FFFFFF, 32'hE47FFFFF, 3'b000, 2, 1'b1);
    run_op("trunc",   1'b0, 8'd127, 25'h1FFFFFF, 32'h407FFFFF, 3'b000, 2, 1'b1);

    // Backpressure: result held, no new sum accepted while out_ready is low
    run_op("bp", 1'b0, 8'd127, 25'h0C00000, 32'h3FC00000, 3'b000, 2, 1'b0);
    in_valid = 1'b1;
    in_exp   = 8'd10;
    in_mant  = 25'h1000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp.valid", {31'b0, out_valid}, 32'd1);
      chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp.result", out_result, 32'h3FC00000);
      chk("bp.flags", {29'b0, out_zero, out_ovf, out_unf}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.drop", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a long shift sequence
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_exp   = 8'd130;
    in_mant  = 25'h0000001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst.in_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst.result", out_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.no_output", {31'b0, out_valid}, 32'd0);
    run_op("after_rst", 1'b0, 8'd127, 25'h0C00000, 32'h3FC00000, 3'b000, 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_normalize.md
Name: fpu_normalize

Overview:
- Sequential normalise/pack stage that sits directly downstream of the combinational FPU adder datapath.
- Consumes the raw sum: sign, exponent of the larger operand, and a 25-bit mantissa with carry bit 24 and hidden bit 23.
- Renormalises one bit per cycle, detects zero, overflow and underflow, and packs an IEEE 754 single-precision word.
- Handles cancellation results that the adder itself cannot normalise; valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width; internal mantissa is MAN_W+2 bits.
- FLUSH_DENORM, 1, denormals flushed to signed zero; only value 1 is supported.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream sum valid
- in_ready  output  1  stage can accept a sum
- in_sign  input  1  result sign
- in_exp  input  EXP_W  biased exponent of larger operand
- in_mant  input  MAN_W+2  raw sum: bit 24 carry, bit 23 hidden
- out_valid  output  1  packed result valid
- out_ready  input  1  downstream accepts result
- out_result  output  32  packed IEEE 754 word
- out_zero  output  1  result is ±0 from exact zero mantissa
- out_ovf  output  1  exponent overflow, result is ±inf
- out_unf  output  1  underflow, result flushed to ±0

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on rst_n.
  - State goes to IDLE.
  - in_ready=0 while rst_n low, 1 from the first cycle after release.
  - out_valid=0, out_result=0, all flags 0.
  - Reset mid-operation discards the operand; no partial output is ever presented.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch sign, exponent (zero-extended to EXP_W+1 bits) and mantissa; clear the shift counter; go to SHIFT.
- SHIFT: in_ready=0. One rule is evaluated per cycle, in priority order:
  - in_exp==255 (latched): result ±inf, mantissa 0, no flag; go DONE.
  - mant==0: result ±0, out_zero=1; go DONE.
  - mant[24]==1: right shift by 1, exp+1.
    - If the new exp>=255: ±inf, out_ovf=1.
    - Otherwise pack normally.
    - Go DONE.
  - mant[23]==1: pack {sign, exp[7:0], mant[22:0]}; go DONE.
  - exp<=1 with mant[23]==0: ±0, out_unf=1; go DONE.
  - Otherwise: left shift by 1, exp-1, counter+1; stay in SHIFT.
  - Counter reaching MAN_W+1 forces the underflow outcome. This is a safety bound only and is unreachable with a nonzero mantissa.
- DONE:
  - out_valid=1; out_result and flags are held stable while out_ready=0.
  - On out_ready, go IDLE and drop out_valid.
  - out_result and flags keep their last value; they are don't-care when out_valid=0.
- Latency, accept edge to first cycle of out_valid: 2 cycles for already-normal, carry, zero or special inputs; 2+k cycles for k left shifts.
- Throughput: the stage is not pipelined. Minimum 3 cycles per operation, with one IDLE bubble between results.
- Arithmetic: exponent register is EXP_W+1 bits, so overflow and underflow are detected without wrap. No rounding; the shifted-out bit on carry is truncated.
- Flags are mutually exclusive; at most one is high per result.

Decomposition:
- Shared package fpu_pkg holds:
  - constants EXP_W, MAN_W, EXP_BIAS=127, EXP_MAX=255;
  - the state enum IDLE/SHIFT/DONE;
  - a flags struct {zero, ovf, unf}.
- One combinational sub-module, fpu_pack: sign, exponent and fraction plus a special-case select in; 32-bit word out. It will be reused by the future mul/div stages.
- FSM, shift register and counter live in fpu_normalize.

Test Plan:
- 1.0+1.0 carry: sign=0, exp=127, mant=25'h1000000 -> out_result=0x40000000, no flags, out_valid 2 cycles after accept.
- Already normal: exp=127, mant=25'h0C00000 -> 0x3FC00000 at latency 2.
- Cancellation: sign=1, exp=130, mant=25'h0000001 -> 23 shifts, out_result=0xB5800000 at latency 25; in_ready low throughout.
- Zero and overflow:
  - exp=100, mant=0 -> 0x00000000 with out_zero=1.
  - exp=254, mant=25'h1000000 -> 0x7F800000 with out_ovf=1.
- Underflow: exp=3, mant=25'h0000100 -> 0x00000000 with out_unf=1 once exp reaches 1.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles: result and flags stable, no new input accepted.
  - Assert rst_n=0 mid-SHIFT: out_valid and in_ready drop immediately.
  - The next operation after release completes correctly.
